voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Shares NVOICES oscillator voices among note-on/note-off requests from the button decoder and the sequencer.
- Runs a request/ready handshake and scans a voice table serially, one voice per cycle.
- Chooses a voice by retrigger match, then free voice, then oldest-voice steal.
- Publishes per-voice note number and gate. Outputs update only on sample_clock rising edges, so oscillators never see a mid-sample change.

Parameters:
- NVOICES, 4, number of voices; 2..16.
- NOTEW, 4, note index width; downstream increment ROM maps note to phase increment.
- AGEW, 8, per-voice age counter width; saturating.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- sample_clock  in  1  slow sample-rate level from the divider; rising edge detected in clk domain.
- note_valid  in  1  request present.
- note_ready  out  1  allocator can accept a request.
- note_on  in  1  1 = note-on, 0 = note-off; sampled with the handshake.
- note_num  in  NOTEW  note index; sampled with the handshake.
- voice_gate  out  NVOICES  bit v = voice v sounding.
- voice_note  out  NVOICES*NOTEW  voice v note at bits [v*NOTEW +: NOTEW].
- alloc_valid  out  1  one-cycle pulse when the table is written.
- alloc_voice  out  clog2(NVOICES)  voice written; valid with alloc_valid.
- steal  out  1  one-cycle pulse with alloc_valid when an active voice was stolen.

Behaviour:
- Reset (async assert, sync release):
  - table active=0, note=0, age=0.
  - voice_gate=0, voice_note=0, alloc_valid=0, alloc_voice=0, steal=0.
  - FSM=IDLE, note_ready=1, sample_clock edge detector history=0.
  - Reset mid-scan discards the request in flight.
- FSM IDLE:
  - note_ready=1 only in IDLE.
  - Handshake at cycle T when note_valid && note_ready: latch note_on/note_num, idx=0, go SCAN.
- FSM SCAN:
  - Examines voice idx in cycle T+1+idx; after idx=NVOICES-1, go COMMIT.
  - Fixed latency: NVOICES scan cycles regardless of early hits.
- Note-on selection, priority order:
  1. Active voice with note == note_num (retrigger), lowest index.
  2. Lowest-index inactive voice.
  3. Active voice with maximum age, lowest index on tie (steal=1).
- Note-off: lowest-index active voice with matching note is released. No match means the request is dropped: no alloc_valid, table unchanged.
- COMMIT (cycle T+NVOICES+1):
  - Note-on: active=1, note=note_num, age=0 for the chosen voice. Every other active voice age += 1, saturating at 2^AGEW-1. Inactive ages are untouched.
  - Note-off: chosen voice active=0, age=0; other ages unchanged.
  - alloc_valid=1 and alloc_voice=chosen on any table write. steal=1 only for case 3.
  - Return to IDLE; note_ready=1 at T+NVOICES+2. Back-to-back requests accepted every NVOICES+2 cycles.
- Output shadowing:
  - Register sample_clock; edge = sc & ~sc_q.
  - In the cycle after an edge is detected, voice_gate/voice_note load from the table.
  - If COMMIT and the load happen in the same cycle, the load takes the pre-COMMIT table. The new value appears on the next edge.
- Retrigger still pulses alloc_valid, so the downstream envelope restarts; the gate stays 1 through the next load.
- note_num/note_on changes while not handshaking are ignored. Holding note_valid high issues one request per handshake.

Test Plan:
- Reset release, NVOICES=4, no stimulus -> note_ready=1, voice_gate=0000, voice_note=0 for 10 sample edges.
- Note-on 5 at T -> note_ready low T+1..T+5; alloc_valid, alloc_voice=0, steal=0 at T+5; voice_gate=0001, voice_note[3:0]=5 after the next sample edge, not before.
- Note-on 1,2,3,4 then note-on 6 -> voices 0..3 allocated in order; note 6 steals voice 0 (age 3, the largest), steal=1, alloc_voice=0.
- Note-on 2 while 2 is on voice 1 -> alloc_voice=1, steal=0, voice 1 age=0, voice_gate unchanged.
- Note-off 7 with no voice on 7 -> no alloc_valid, table unchanged, note_ready back after 6 cycles. Note-off 3 (voice 2) -> voice_gate bit 2 clears at the next sample edge.
- rst asserted during SCAN idx=2 -> all outputs zero immediately (async). After release: note_ready=1, no alloc_valid for the aborted request.

Source files
------------

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - shares NVOICES oscillator voices among note-on/note-off requests
module voice_allocator #(
  parameter int NVOICES = 4,
  parameter int NOTEW   = 4,
  parameter int AGEW    = 8,
  localparam int VW     = (NVOICES > 1) ? $clog2(NVOICES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_clock,
  input  logic                     note_valid,
  output logic                     note_ready,
  input  logic                     note_on,
  input  logic [NOTEW-1:0]         note_num,
  output logic [NVOICES-1:0]       voice_gate,
  output logic [NVOICES*NOTEW-1:0] voice_note,
  output logic                     alloc_valid,
  output logic [VW-1:0]            alloc_voice,
  output logic                     steal
);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  localparam logic [AGEW-1:0] AGE_MAX = '1;
  localparam logic [VW-1:0]   LAST    = VW'(NVOICES - 1);

  state_t             state;
  logic [NVOICES-1:0] active;
  logic [NOTEW-1:0]   note_tab [NVOICES];
  logic [AGEW-1:0]    age_tab  [NVOICES];

  logic               req_on;
  logic [NOTEW-1:0]   req_note;
  logic [VW-1:0]      idx;
  logic               hit_found, free_found, old_found;
  logic [VW-1:0]      hit_idx, free_idx, old_idx;
  logic [AGEW-1:0]    old_age;
  logic               commit_write;
  logic [VW-1:0]      commit_voice;
  logic               sc_q;
  logic               sc_edge;

  logic               n_hit_found, n_free_found, n_old_found;
  logic [VW-1:0]      n_hit_idx, n_free_idx, n_old_idx;
  logic [AGEW-1:0]    n_old_age;
  logic               pick_write, pick_steal;
  logic [VW-1:0]      pick_voice;

  assign sc_edge = sample_clock & ~sc_q;

  // Fold voice idx into the running scan results; the first hit keeps the lowest index.
  always_comb begin
    n_hit_found  = hit_found;
    n_hit_idx    = hit_idx;
    n_free_found = free_found;
    n_free_idx   = free_idx;
    n_old_found  = old_found;
    n_old_idx    = old_idx;
    n_old_age    = old_age;
    if (active[idx] && note_tab[idx] == req_note && !hit_found) begin
      n_hit_found = 1'b1;
      n_hit_idx   = idx;
    end
    if (!active[idx] && !free_found) begin
      n_free_found = 1'b1;
      n_free_idx   = idx;
    end
    if (active[idx] && (!old_found || age_tab[idx] > old_age)) begin
      n_old_found = 1'b1;
      n_old_idx   = idx;
      n_old_age   = age_tab[idx];
    end
  end

  always_comb begin
    pick_write = 1'b0;
    pick_steal = 1'b0;
    pick_voice = n_hit_idx;
    if (req_on) begin
      pick_write = 1'b1;
      if (n_hit_found) begin
        pick_voice = n_hit_idx;
      end else if (n_free_found) begin
        pick_voice = n_free_idx;
      end else begin
        pick_voice = n_old_idx;
        pick_steal = 1'b1;
      end
    end else if (n_hit_found) begin
      pick_write = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      note_ready   <= 1'b1;
      active       <= '0;
      for (int v = 0; v < NVOICES; v++) begin
        note_tab[v] <= '0;
        age_tab[v]  <= '0;
      end
      req_on       <= 1'b0;
      req_note     <= '0;
      idx          <= '0;
      hit_found    <= 1'b0;
      free_found   <= 1'b0;
      old_found    <= 1'b0;
      hit_idx      <= '0;
      free_idx     <= '0;
      old_idx      <= '0;
      old_age      <= '0;
      commit_write <= 1'b0;
      commit_voice <= '0;
      sc_q         <= 1'b0;
      voice_gate   <= '0;
      voice_note   <= '0;
      alloc_valid  <= 1'b0;
      alloc_voice  <= '0;
      steal        <= 1'b0;
    end else begin
      sc_q        <= sample_clock;
      alloc_valid <= 1'b0;
      steal       <= 1'b0;

      // Shadow load sees the table as it was before any same-cycle commit.
      if (sc_edge) begin
        for (int v = 0; v < NVOICES; v++) begin
          voice_gate[v]                <= active[v];
          voice_note[v*NOTEW +: NOTEW] <= note_tab[v];
        end
      end

      case (state)
        IDLE: begin
          if (note_valid && note_ready) begin
            req_on     <= note_on;
            req_note   <= note_num;
            idx        <= '0;
            hit_found  <= 1'b0;
            free_found <= 1'b0;
            old_found  <= 1'b0;
            old_age    <= '0;
            note_ready <= 1'b0;
            state      <= SCAN;
          end
        end
        SCAN: begin
          hit_found  <= n_hit_found;
          hit_idx    <= n_hit_idx;
          free_found <= n_free_found;
          free_idx   <= n_free_idx;
          old_found  <= n_old_found;
          old_idx    <= n_old_idx;
          old_age    <= n_old_age;
          if (idx == LAST) begin
            commit_write <= pick_write;
            commit_voice <= pick_voice;
            alloc_valid  <= pick_write;
            if (pick_write) alloc_voice <= pick_voice;
            steal        <= pick_steal;
            state        <= COMMIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        COMMIT: begin
          if (commit_write) begin
            for (int v = 0; v < NVOICES; v++) begin
              if (VW'(v) == commit_voice) begin
                active[v]  <= req_on;
                age_tab[v] <= '0;
                if (req_on) note_tab[v] <= req_note;
              end else if (req_on && active[v] && age_tab[v] != AGE_MAX) begin
                age_tab[v] <= age_tab[v] + 1'b1;
              end
            end
          end
          note_ready <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - randomized and directed check of voice_allocator against a table model
module tb_voice_allocator;
  localparam int NV = 4;
  localparam int NW = 4;
  localparam int AW = 3;
  localparam int VW = 2;
  localparam int AMAX = (1 << AW) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sample_clock = 1'b0;
  logic             note_valid = 1'b0;
  logic             note_ready;
  logic             note_on = 1'b0;
  logic [NW-1:0]    note_num = '0;
  logic [NV-1:0]    voice_gate;
  logic [NV*NW-1:0] voice_note;
  logic             alloc_valid;
  logic [VW-1:0]    alloc_voice;
  logic             steal;

  always #5 clk = ~clk;

  voice_allocator #(.NVOICES(NV), .NOTEW(NW), .AGEW(AW)) dut (
    .clk(clk), .rst(rst), .sample_clock(sample_clock),
    .note_valid(note_valid), .note_ready(note_ready),
    .note_on(note_on), .note_num(note_num),
    .voice_gate(voice_gate), .voice_note(voice_note),
    .alloc_valid(alloc_valid), .alloc_voice(alloc_voice), .steal(steal)
  );

  int tests = 0;
  int fails = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference table and expected outputs
  logic             m_active [NV];
  int               m_note   [NV];
  int               m_age    [NV];
  logic [NV-1:0]    e_gate;
  logic [NV*NW-1:0] e_note;
  logic             e_ready, e_alloc, e_steal, m_sc;
  int               e_voice, k;
  logic             d_write, d_steal, d_on;
  int               d_voice, d_num;
  logic             sc_auto = 1'b0;
  logic             sc_manual = 1'b0;

  task automatic decide(input logic on, input int num);
    int hit, free, best;
    d_on = on; d_num = num; d_write = 1'b0; d_steal = 1'b0; d_voice = 0;
    hit = -1; free = -1; best = -1;
    for (int v = 0; v < NV; v++) begin
      if (m_active[v] && m_note[v] == num && hit < 0) hit = v;
      if (!m_active[v] && free < 0) free = v;
      if (m_active[v] && (best < 0 || m_age[v] > m_age[best])) best = v;
    end
    if (on) begin
      d_write = 1'b1;
      if (hit >= 0) d_voice = hit;
      else if (free >= 0) d_voice = free;
      else begin d_voice = best; d_steal = 1'b1; end
    end else if (hit >= 0) begin
      d_write = 1'b1;
      d_voice = hit;
    end
  endtask

  task automatic apply_commit();
    if (!d_write) return;
    for (int v = 0; v < NV; v++)
      if (v != d_voice && d_on && m_active[v] && m_age[v] < AMAX) m_age[v]++;
    m_active[d_voice] = d_on;
    m_age[d_voice] = 0;
    if (d_on) m_note[d_voice] = d_num;
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int v = 0; v < NV; v++) begin m_active[v] = 1'b0; m_note[v] = 0; m_age[v] = 0; end
        e_gate = '0; e_note = '0; e_ready = 1'b1; e_alloc = 1'b0; e_steal = 1'b0;
        e_voice = 0; k = 0; m_sc = 1'b0;
      end else begin
        if (sample_clock && !m_sc)
          for (int v = 0; v < NV; v++) begin
            e_gate[v] = m_active[v];
            e_note[v*NW +: NW] = NW'(m_note[v]);
          end
        m_sc = sample_clock;
        e_alloc = 1'b0; e_steal = 1'b0;
        if (!e_ready) begin
          k++;
          if (k == NV) begin
            e_alloc = d_write; e_steal = d_steal;
            if (d_write) e_voice = d_voice;
          end else if (k == NV + 1) begin
            apply_commit();
            e_ready = 1'b1;
          end
        end else if (note_valid) begin
          decide(note_on, int'(note_num));
          e_ready = 1'b0;
          k = 0;
        end
      end
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("note_ready", note_ready, e_ready);
        check("alloc_valid", alloc_valid, e_alloc);
        check("steal", steal, e_steal);
        if (e_alloc) check("alloc_voice", alloc_voice, e_voice);
        check("voice_gate", voice_gate, e_gate);
        check("voice_note", voice_note, e_note);
      end
    end
  endtask

  task automatic sc_driver();
    forever begin
      @(negedge clk);
      if (sc_auto) begin
        if ($urandom_range(0, 6) == 0) sample_clock = ~sample_clock;
      end else sample_clock = sc_manual;
    end
  endtask

  task automatic sc_pulse();
    sc_manual = 1'b1; repeat (3) @(negedge clk);
    sc_manual = 1'b0; repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; repeat (2) @(negedge clk);
    rst = 1'b0; @(negedge clk);
  endtask

  task automatic send(input logic on, input int num, output logic got, output int voice, output logic stl);
    int w;
    w = 0;
    while (!note_ready && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) check("ready_timeout", note_ready, 1'b1);
    note_valid = 1'b1; note_on = on; note_num = NW'(num);
    @(negedge clk);
    note_valid = 1'b0; note_on = 1'($urandom); note_num = NW'($urandom);
    got = 1'b0; voice = -1; stl = 1'b0;
    for (int i = 0; i < NV + 2; i++) begin
      if (alloc_valid) begin got = 1'b1; voice = int'(alloc_voice); stl = steal; end
      @(negedge clk);
    end
  endtask

  logic got, stl, seen;
  int   vce;

  initial begin
    fork
      model_loop();
      compare_loop();
      sc_driver();
    join_none

    do_reset();
    check("rst_ready", note_ready, 1'b1);
    check("rst_gate", voice_gate, '0);
    check("rst_alloc", alloc_valid, 1'b0);
    for (int i = 0; i < 10; i++) begin
      sc_pulse();
      check("idle_gate", voice_gate, '0);
      check("idle_note", voice_note, '0);
      check("idle_ready", note_ready, 1'b1);
    end

    send(1'b1, 5, got, vce, stl);
    check("on5_valid", got, 1'b1);
    check("on5_voice", vce, 0);
    check("on5_steal", stl, 1'b0);
    check("on5_gate_before_edge", voice_gate, '0);
    sc_pulse();
    check("on5_gate", voice_gate, 4'b0001);
    check("on5_note", voice_note[3:0], 4'd5);

    do_reset();
    for (int n = 1; n <= 4; n++) begin
      send(1'b1, n, got, vce, stl);
      check("fill_voice", vce, n - 1);
      check("fill_steal", stl, 1'b0);
    end
    send(1'b1, 6, got, vce, stl);
    check("steal_valid", got, 1'b1);
    check("steal_voice", vce, 0);
    check("steal_flag", stl, 1'b1);
    sc_pulse();
    check("full_gate", voice_gate, 4'b1111);

    send(1'b1, 2, got, vce, stl);
    check("retrig_voice", vce, 1);
    check("retrig_steal", stl, 1'b0);
    sc_pulse();
    check("retrig_gate", voice_gate, 4'b1111);

    send(1'b0, 7, got, vce, stl);
    check("off7_no_alloc", got, 1'b0);
    send(1'b0, 3, got, vce, stl);
    check("off3_voice", vce, 2);
    check("off3_gate_before_edge", voice_gate, 4'b1111);
    sc_pulse();
    check("off3_gate", voice_gate, 4'b1011);
    check("off3_notes", voice_note, 16'h4326);

    while (!note_ready) @(negedge clk);
    note_valid = 1'b1; note_on = 1'b1; note_num = 4'd9;
    @(negedge clk);
    note_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_gate", voice_gate, '0);
    check("abort_note", voice_note, '0);
    check("abort_alloc", alloc_valid, 1'b0);
    check("abort_ready", note_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < NV + 3; i++) begin
      @(negedge clk);
      if (alloc_valid) seen = 1'b1;
    end
    check("abort_no_alloc", seen, 1'b0);
    check("abort_ready_after", note_ready, 1'b1);

    sc_auto = 1'b1;
    for (int r = 0; r < 250; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send($urandom_range(0, 9) < 7, int'($urandom_range(0, 7)), got, vce, stl);
    end
    sc_auto = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
